// File: rtl/layer_2_stream_ctrl_if.sv
// Stream bundle between a pixel source, the layer-2 stream controller and the
// featuremap conv bank.
//   s_data/s_valid/s_ready          : source pixel handshake
//   conv_data_in/conv_valid_in      : pixel strobe into the conv bank
//   conv_valid_out                  : result strobe back from the conv bank
// Modports:
//   slave  : controller side (accepts source pixels, feeds the conv bank)
//   master : environment side (source and conv bank)
interface layer_2_stream_ctrl_if #(
  parameter int unsigned DATA_IN_WIDTH = 512
);
  logic [DATA_IN_WIDTH-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_IN_WIDTH-1:0] conv_data_in;
  logic                     conv_valid_in;
  logic                     conv_valid_out;

  modport master (
    output s_data, s_valid, conv_valid_out,
    input  s_ready, conv_data_in, conv_valid_in
  );

  modport slave (
    input  s_data, s_valid, conv_valid_out,
    output s_ready, conv_data_in, conv_valid_in
  );
endinterface

// File: rtl/layer_2_stream_ctrl.sv
// Layer-2 frame stream controller.
// Walks one IMG_SIZE x IMG_SIZE frame from the source into the featuremap conv
// bank, then waits for the bank to return all of its results.
// FSM: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
// Ports:
//   Clk    : sole clock, rising edge
//   Rst    : synchronous active-high reset
//   start  : frame start request (only honoured in IDLE)
//   stream : layer_2_stream_ctrl_if.slave (source handshake, conv bank strobes)
//   busy   : high in every state except IDLE
//   done   : one-cycle end-of-frame pulse
//   err    : sticky error (stray/overflow result, drain timeout)
// Build option: define LAYER_2_ZERO_PAD_EN to wrap the frame in a one-pixel
// zero border generated locally (W = IMG_SIZE+2, E = IMG_SIZE^2).
module layer_2_stream_ctrl #(
  parameter int unsigned IMG_SIZE      = 208,
  parameter int unsigned DATA_IN_WIDTH = 512,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  layer_2_stream_ctrl_if.slave stream,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LAYER_2_ZERO_PAD_EN
  localparam int unsigned W = IMG_SIZE + 2;
  localparam int unsigned E = IMG_SIZE * IMG_SIZE;
`else
  localparam int unsigned W = IMG_SIZE;
  localparam int unsigned E = (IMG_SIZE - 2) * (IMG_SIZE - 2);
`endif

  localparam int unsigned RC_W  = $clog2(IMG_SIZE + 2);
  localparam int unsigned OUT_W = $clog2(E + 1);
  localparam int unsigned TO_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [RC_W-1:0]  LAST_RC = RC_W'(W - 1);
  localparam logic [OUT_W-1:0] E_C     = OUT_W'(E);
  localparam logic [TO_W-1:0]  TO_C    = TO_W'(DRAIN_TIMEOUT);

  logic [1:0]               state_q, state_d;
  logic [RC_W-1:0]          col_q, col_d;
  logic [RC_W-1:0]          row_q, row_d;
  logic [OUT_W-1:0]         out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]          idle_cnt_q, idle_cnt_d;
  logic [DATA_IN_WIDTH-1:0] data_q, data_d;
  logic                     cvi_q, cvi_d;
  logic                     err_q, err_d;

  logic                     feed_ready;
  logic                     s_ready_c;
  logic                     hs;
  logic                     emit;
  logic [DATA_IN_WIDTH-1:0] emit_data;

`ifdef LAYER_2_ZERO_PAD_EN
  logic pad_pos;
  assign pad_pos    = (row_q == '0) || (row_q == LAST_RC) ||
                      (col_q == '0) || (col_q == LAST_RC);
  assign feed_ready = !pad_pos;
  // Border pixels are produced locally, so they advance the walk without a handshake.
  assign emit       = (state_q == S_FEED) && (pad_pos || hs);
  assign emit_data  = pad_pos ? '0 : stream.s_data;
`else
  assign feed_ready = 1'b1;
  assign emit       = hs;
  assign emit_data  = stream.s_data;
`endif

  assign s_ready_c = (state_q == S_FEED) && feed_ready;
  assign hs        = stream.s_valid && s_ready_c;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    out_cnt_d  = out_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    cvi_d      = 1'b0;
    err_d      = err_q;

    // Result counting is shared by FEED and DRAIN so a result landing on the
    // FEED->DRAIN edge is already in out_cnt_q when DRAIN first evaluates.
    if (((state_q == S_FEED) || (state_q == S_DRAIN)) && stream.conv_valid_out) begin
      if (out_cnt_q == E_C) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FEED;
          err_d      = 1'b0;
          col_d      = '0;
          row_d      = '0;
          out_cnt_d  = '0;
          idle_cnt_d = '0;
        end
        if (stream.conv_valid_out) begin
          err_d = 1'b1;
        end
      end

      S_FEED: begin
        if (emit) begin
          cvi_d  = 1'b1;
          data_d = emit_data;
          if (col_q == LAST_RC) begin
            col_d = '0;
            if (row_q == LAST_RC) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (stream.conv_valid_out) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (out_cnt_d == E_C) begin
          state_d = S_DONE;
        end else if (!stream.conv_valid_out && (idle_cnt_d == TO_C)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        col_d      = '0;
        row_d      = '0;
        out_cnt_d  = '0;
        idle_cnt_d = '0;
        if (stream.conv_valid_out) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      out_cnt_q  <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      cvi_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_cnt_q  <= out_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      cvi_q      <= cvi_d;
      err_q      <= err_d;
    end
  end

  assign stream.s_ready       = s_ready_c;
  assign stream.conv_data_in  = data_q;
  assign stream.conv_valid_in = cvi_q;
  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_DONE);
  assign err                  = err_q;

endmodule

// File: doc/layer_2_stream_ctrl.md
LAYER_2_STREAM_CTRL -- requirements
Module: layer_2_stream_ctrl

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 208, input feature-map width and height in pixels.
REQ-002 SHALL have parameter DATA_IN_WIDTH, default 512, packed 16-channel pixel width (16 x 32-bit float).
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 4096, maximum idle cycles in DRAIN before abort.
REQ-004 SHALL have port Clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start, input, 1, frame start request.
REQ-007 SHALL have port s_data, input, DATA_IN_WIDTH, source pixel.
REQ-008 SHALL have port s_valid, input, 1, source pixel valid.
REQ-009 SHALL have port s_ready, output, 1, controller accepts s_data this cycle.
REQ-010 SHALL have port conv_data_in, output, DATA_IN_WIDTH, pixel to the featuremap conv bank.
REQ-011 SHALL have port conv_valid_in, output, 1, conv bank input strobe.
REQ-012 SHALL have port conv_valid_out, input, 1, conv bank result strobe.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle end-of-frame pulse.
REQ-015 SHALL have port err, output, 1, sticky error flag.

Function
REQ-016 SHALL implement FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
REQ-017 SHALL leave IDLE for FEED on the first cycle start=1 (start seen in IDLE); start outside IDLE is ignored.
REQ-018 SHALL, in FEED, drive s_ready=1 except on padding positions (REQ-031); s_ready=0 in IDLE, DRAIN and DONE.
REQ-019 SHALL define handshake as s_valid & s_ready; on handshake, next cycle conv_data_in=s_data and conv_valid_in=1; otherwise conv_valid_in=0 and conv_data_in holds.
REQ-020 SHALL keep col (0..W-1) and row (0..W-1) counters, W = IMG_SIZE, advancing per emitted pixel; col wraps to 0 and row increments at col=W-1.
REQ-021 SHALL move FEED -> DRAIN the cycle after the pixel at row=W-1, col=W-1 is emitted.
REQ-022 SHALL count conv_valid_out pulses in FEED and DRAIN; expected count E = (IMG_SIZE-2)^2.
REQ-023 SHALL move DRAIN -> DONE when count reaches E, including on a conv_valid_out in the same cycle as FEED -> DRAIN.
REQ-024 SHALL, in DRAIN, count consecutive cycles without conv_valid_out; on reaching DRAIN_TIMEOUT set err and move to DONE.
REQ-025 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE with all counters cleared.
REQ-026 SHALL set err if conv_valid_out=1 in IDLE or DONE, or if count would exceed E; err clears only on Rst or on start accepted in IDLE.
REQ-027 SHALL size counters as clog2(IMG_SIZE+2) (row/col), clog2(E+1) (output), clog2(DRAIN_TIMEOUT+1) (timeout), all unsigned.

Reset
REQ-028 SHALL on Rst=1 force next cycle: state IDLE, s_ready=0, conv_valid_in=0, conv_data_in=0, busy=0, done=0, err=0, all counters 0.
REQ-029 SHALL give Rst priority over start, handshakes and conv_valid_out in the same cycle; reset mid-frame discards the frame, no done pulse.

Configuration
REQ-030 SHALL support macro LAYER_2_ZERO_PAD_EN.
REQ-031 SHALL, with LAYER_2_ZERO_PAD_EN defined, use W = IMG_SIZE+2; on border positions (row or col = 0 or W-1) drive s_ready=0 and emit a zero pixel with conv_valid_in=1 without a handshake; E = IMG_SIZE^2.
REQ-032 SHALL, without the macro, contain no padding logic and behave per REQ-020/REQ-022 (W = IMG_SIZE, E = (IMG_SIZE-2)^2).

Verification
REQ-033 SHALL cover: IMG_SIZE=4, no pad, s_valid held 1 -> 16 consecutive conv_valid_in; model returns 4 conv_valid_out -> done one cycle, busy=0 after.
REQ-034 SHALL cover: IMG_SIZE=4, s_valid toggling 1/0 -> conv_valid_in exactly 16 times, each one cycle after a handshake, data matches in order.
REQ-035 SHALL cover: LAYER_2_ZERO_PAD_EN, IMG_SIZE=4 -> 36 conv_valid_in, 20 all-zero, s_ready=0 on those; 16 conv_valid_out -> done.
REQ-036 SHALL cover: DRAIN_TIMEOUT=8, model returns 3 of 4 outputs -> err=1 and done 8 idle cycles after the last output.
REQ-037 SHALL cover: Rst after 5 handshakes -> all outputs 0 next cycle, no done; next start restarts at row 0, col 0.
REQ-038 SHALL cover: start pulsed during FEED -> ignored; conv_valid_out in IDLE -> err=1, cleared by next accepted start.
